// File: rtl/counter_op_sequencer_if.sv
// Requester/counter-side bundle of the counter op sequencer.
// master = requester/counter side, slave = the sequencer.
interface counter_op_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);
  logic             req_a;
  logic             req_b;
  logic [2:0]       op_a;
  logic [2:0]       op_b;
  logic [WIDTH-1:0] arg_a;
  logic [WIDTH-1:0] arg_b;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic             ack_a;
  logic             ack_b;
  logic             busy;
  logic             owner;
  logic             do_reset;
  logic             do_load;
  logic             do_increment;
  logic             do_decrement;
  logic             do_shift_l2r;
  logic             do_shift_r2l;
  logic [WIDTH-1:0] counter_in_data;
  logic             counter_in_msb;
  logic             counter_in_lsb;

  modport master (
    output req_a, req_b, op_a, op_b, arg_a, arg_b, cnt_a, cnt_b,
    input  ack_a, ack_b, busy, owner,
    input  do_reset, do_load, do_increment, do_decrement, do_shift_l2r, do_shift_r2l,
    input  counter_in_data, counter_in_msb, counter_in_lsb
  );

  modport slave (
    input  req_a, req_b, op_a, op_b, arg_a, arg_b, cnt_a, cnt_b,
    output ack_a, ack_b, busy, owner,
    output do_reset, do_load, do_increment, do_decrement, do_shift_l2r, do_shift_r2l,
    output counter_in_data, counter_in_msb, counter_in_lsb
  );
endinterface

// File: rtl/counter_op_sequencer.sv
// Round-robin arbiter for two requesters plus step sequencer that turns a granted
// command into one-hot counter strobes, serialising shift arguments bit by bit.
//
//  state | meaning
//  IDLE  | no command; arbitrate pending requests
//  RUN   | issuing steps 0..N-1 of the latched command
module counter_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input logic                   clk,
  input logic                   rst,
  counter_op_sequencer_if.slave bus
);

  localparam int IDX_W = $clog2(WIDTH);

  localparam logic [2:0] OP_RESET = 3'd1;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_INC   = 3'd3;
  localparam logic [2:0] OP_DEC   = 3'd4;
  localparam logic [2:0] OP_SHR   = 3'd5;
  localparam logic [2:0] OP_SHL   = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic             owner_q, owner_d;
  logic             busy_q, busy_d;
  logic             ack_a_q, ack_a_d;
  logic             ack_b_q, ack_b_d;
  logic             do_reset_q, do_reset_d;
  logic             do_load_q, do_load_d;
  logic             do_inc_q, do_inc_d;
  logic             do_dec_q, do_dec_d;
  logic             do_l2r_q, do_l2r_d;
  logic             do_r2l_q, do_r2l_d;
  logic             msb_q, msb_d;
  logic             lsb_q, lsb_d;

  logic             drive;
  logic             grant_b;
  logic [IDX_W-1:0] idx;

  function automatic logic is_repeat(input logic [2:0] op);
    return (op == OP_INC) || (op == OP_DEC) || (op == OP_SHR) || (op == OP_SHL);
  endfunction

  // Outputs are computed for the step about to be entered and registered, so the
  // first strobe appears in the cycle right after the grant with no extra latency.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    arg_d      = arg_q;
    last_d     = last_q;
    k_d        = k_q;
    owner_d    = owner_q;
    drive      = 1'b0;
    grant_b    = 1'b0;
    idx        = '0;
    busy_d     = 1'b0;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    do_reset_d = 1'b0;
    do_load_d  = 1'b0;
    do_inc_d   = 1'b0;
    do_dec_d   = 1'b0;
    do_l2r_d   = 1'b0;
    do_r2l_d   = 1'b0;
    msb_d      = 1'b0;
    lsb_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_a || bus.req_b) begin
          grant_b = bus.req_b && (!bus.req_a || !owner_q);
          owner_d = grant_b;
          op_d    = grant_b ? bus.op_b : bus.op_a;
          arg_d   = grant_b ? bus.arg_b : bus.arg_a;
          // Count field minus one wraps 0 to the all-ones last step, i.e. 2**CNT_W steps.
          last_d  = is_repeat(op_d) ? (grant_b ? bus.cnt_b : bus.cnt_a) - 1'b1 : '0;
          k_d     = '0;
          state_d = RUN;
          drive   = 1'b1;
        end
      end
      RUN: begin
        if (k_q == last_q) begin
          state_d = IDLE;
        end else begin
          k_d   = k_q + 1'b1;
          drive = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (drive) begin
      busy_d  = 1'b1;
      ack_a_d = (k_d == last_d) && !owner_d;
      ack_b_d = (k_d == last_d) && owner_d;
      case (op_d)
        OP_RESET: do_reset_d = 1'b1;
        OP_LOAD:  do_load_d  = 1'b1;
        OP_INC:   do_inc_d   = 1'b1;
        OP_DEC:   do_dec_d   = 1'b1;
        OP_SHR: begin
          do_l2r_d = 1'b1;
          idx      = IDX_W'(int'(k_d) % WIDTH);
          msb_d    = arg_d[idx];
        end
        OP_SHL: begin
          do_r2l_d = 1'b1;
          idx      = IDX_W'(WIDTH - 1 - (int'(k_d) % WIDTH));
          lsb_d    = arg_d[idx];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      arg_q      <= '0;
      last_q     <= '0;
      k_q        <= '0;
      owner_q    <= 1'b1;
      busy_q     <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      do_reset_q <= 1'b0;
      do_load_q  <= 1'b0;
      do_inc_q   <= 1'b0;
      do_dec_q   <= 1'b0;
      do_l2r_q   <= 1'b0;
      do_r2l_q   <= 1'b0;
      msb_q      <= 1'b0;
      lsb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      arg_q      <= arg_d;
      last_q     <= last_d;
      k_q        <= k_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      do_reset_q <= do_reset_d;
      do_load_q  <= do_load_d;
      do_inc_q   <= do_inc_d;
      do_dec_q   <= do_dec_d;
      do_l2r_q   <= do_l2r_d;
      do_r2l_q   <= do_r2l_d;
      msb_q      <= msb_d;
      lsb_q      <= lsb_d;
    end
  end

  assign bus.busy            = busy_q;
  assign bus.owner           = owner_q;
  assign bus.ack_a           = ack_a_q;
  assign bus.ack_b           = ack_b_q;
  assign bus.do_reset        = do_reset_q;
  assign bus.do_load         = do_load_q;
  assign bus.do_increment    = do_inc_q;
  assign bus.do_decrement    = do_dec_q;
  assign bus.do_shift_l2r    = do_l2r_q;
  assign bus.do_shift_r2l    = do_r2l_q;
  assign bus.counter_in_data = arg_q;
  assign bus.counter_in_msb  = msb_q;
  assign bus.counter_in_lsb  = lsb_q;

endmodule

// File: tb/tb_counter_op_sequencer.sv
// Bench for counter_op_sequencer: directed and random commands checked against a
// command-level model of arbitration, step sequence and the attached counter.
module tb_counter_op_sequencer;
  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   chk_en = 1'b0;
  int   tests = 0;
  int   fails = 0;
  bit   model_owner;
  logic [15:0] cnt_model;

  always #5 clk = ~clk;

  counter_op_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  counter_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] do_vec();
    return {bus.do_reset, bus.do_load, bus.do_increment, bus.do_decrement,
            bus.do_shift_l2r, bus.do_shift_r2l};
  endfunction

  // {do_reset..do_shift_r2l, msb, lsb, ack_a, ack_b, busy, owner}
  function automatic logic [11:0] obs_vec();
    return {do_vec(), bus.counter_in_msb, bus.counter_in_lsb, bus.ack_a, bus.ack_b,
            bus.busy, bus.owner};
  endfunction

  function automatic logic [15:0] exp_final(input logic [2:0] op, input logic [15:0] c0,
                                            input logic [15:0] arg, input int n);
    logic [31:0] c;
    logic [31:0] a;
    c = {16'h0, c0};
    a = {16'h0, arg};
    case (op)
      3'd1: return 16'h0;
      3'd2: return arg;
      3'd3: return c0 + 16'(n);
      3'd4: return c0 - 16'(n);
      3'd5: if (n >= 16) return arg;
            else return 16'((c >> n) | ((a & ((32'd1 << n) - 32'd1)) << (16 - n)));
      3'd6: if (n >= 16) return arg;
            else return 16'((c << n) | (a >> (16 - n)));
      default: return c0;
    endcase
  endfunction

  // The external counter reacting to whatever strobes the sequencer drives.
  task automatic apply_counter();
    if (bus.do_reset)          cnt_model = 16'h0;
    else if (bus.do_load)      cnt_model = bus.counter_in_data;
    else if (bus.do_increment) cnt_model = cnt_model + 16'd1;
    else if (bus.do_decrement) cnt_model = cnt_model - 16'd1;
    else if (bus.do_shift_l2r) cnt_model = {bus.counter_in_msb, cnt_model[15:1]};
    else if (bus.do_shift_r2l) cnt_model = {cnt_model[14:0], bus.counter_in_lsb};
  endtask

  // Called at a negedge with the DUT in IDLE and requests already driven;
  // returns at the negedge of the IDLE cycle that follows the Ack.
  task automatic run_cmd(input string tag, input bit drop);
    bit          win;
    logic [2:0]  op;
    logic [15:0] arg;
    logic [3:0]  cnt;
    logic [15:0] c0;
    logic [15:0] sh;
    logic [5:0]  dv;
    bit          msb;
    bit          lsb;
    bit          last;
    int          n;
    win = (bus.req_a && bus.req_b) ? !model_owner : bus.req_b;
    op  = win ? bus.op_b  : bus.op_a;
    arg = win ? bus.arg_b : bus.arg_a;
    cnt = win ? bus.cnt_b : bus.cnt_a;
    n   = (op >= 3'd3 && op <= 3'd6) ? ((cnt == 4'd0) ? 16 : int'(cnt)) : 1;
    case (op)
      3'd1: dv = 6'b100000;
      3'd2: dv = 6'b010000;
      3'd3: dv = 6'b001000;
      3'd4: dv = 6'b000100;
      3'd5: dv = 6'b000010;
      3'd6: dv = 6'b000001;
      default: dv = 6'b000000;
    endcase
    model_owner = win;
    c0 = cnt_model;
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      sh   = arg >> (s % 16);
      msb  = (op == 3'd5) ? sh[0] : 1'b0;
      sh   = arg >> (15 - (s % 16));
      lsb  = (op == 3'd6) ? sh[0] : 1'b0;
      last = (s == n - 1);
      check($sformatf("%s step%0d", tag, s), 32'(obs_vec()),
            32'({dv, msb, lsb, last && !win, last && win, 1'b1, win}));
      check($sformatf("%s data%0d", tag, s), 32'(bus.counter_in_data), 32'(arg));
      apply_counter();
      if (last && drop) begin
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
      end
    end
    check({tag, " result"}, 32'(cnt_model), 32'(exp_final(op, c0, arg, n)));
    @(negedge clk);
    check({tag, " idle"}, 32'(obs_vec()), 32'({11'b0, model_owner}));
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("onehot", 32'($countones(do_vec()) <= 1), 32'd1);
      check("ack_rules", 32'(!(bus.ack_a && bus.ack_b) && (!(bus.ack_a || bus.ack_b) || bus.busy)),
            32'd1);
    end
  end

  initial begin
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    bus.op_a  = 3'd0; bus.op_b  = 3'd0;
    bus.arg_a = 16'h0; bus.arg_b = 16'h0;
    bus.cnt_a = 4'd0; bus.cnt_b = 4'd0;
    model_owner = 1'b1;
    cnt_model   = 16'h0;

    #2 rst = 1'b1;
    #1;
    check("reset outs", 32'(obs_vec()), 32'({11'b0, 1'b1}));
    check("reset data", 32'(bus.counter_in_data), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("idle after reset", 32'(obs_vec()), 32'({11'b0, 1'b1}));

    // 1: A LOAD BEEF
    bus.req_a = 1'b1; bus.op_a = 3'd2; bus.arg_a = 16'hBEEF;
    run_cmd("t1_load", 1'b1);
    check("t1 counter", 32'(cnt_model), 32'h0000BEEF);

    // clear counter, then 2: B INC x3
    bus.req_a = 1'b1; bus.op_a = 3'd1;
    run_cmd("t2_clr", 1'b1);
    bus.req_b = 1'b1; bus.op_b = 3'd3; bus.cnt_b = 4'd3;
    run_cmd("t2_inc", 1'b1);
    check("t2 counter", 32'(cnt_model), 32'd3);

    // 4: both held, DEC x1 each; grants alternate A,B,A,B
    bus.op_a = 3'd4; bus.cnt_a = 4'd1; bus.op_b = 3'd4; bus.cnt_b = 4'd1;
    bus.req_a = 1'b1; bus.req_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_cmd($sformatf("t4_rr%0d", i), i == 3);
      check($sformatf("t4 owner%0d", i), 32'(bus.owner), 32'(i % 2));
    end

    // 3: A SHL 16 steps of A5C3
    bus.req_a = 1'b1; bus.op_a = 3'd6; bus.cnt_a = 4'd0; bus.arg_a = 16'hA5C3;
    run_cmd("t3_shl", 1'b1);
    check("t3 counter", 32'(cnt_model), 32'h0000A5C3);

    // 5: reset during step 4 of A SHR x8
    bus.req_a = 1'b1; bus.op_a = 3'd5; bus.cnt_a = 4'd8; bus.arg_a = 16'h3C96;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      check($sformatf("t5 step%0d", s), 32'({bus.do_shift_l2r, bus.busy, bus.owner, bus.ack_a}),
            32'({1'b1, 1'b1, 1'b0, 1'b0}));
      apply_counter();
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5 async clear", 32'(obs_vec()), 32'({11'b0, 1'b1}));
    check("t5 data clear", 32'(bus.counter_in_data), 32'h0);
    bus.req_a = 1'b0;
    model_owner = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t5 quiet%0d", i), 32'(obs_vec()), 32'({11'b0, 1'b1}));
    end
    bus.op_a = 3'd4; bus.cnt_a = 4'd1; bus.op_b = 3'd3; bus.cnt_b = 4'd2;
    bus.req_a = 1'b1; bus.req_b = 1'b1;
    run_cmd("t5_regrant", 1'b1);
    check("t5 first grant A", 32'(bus.owner), 32'd0);

    // 6: B op 7 behaves as NOP
    bus.req_b = 1'b1; bus.op_b = 3'd7; bus.arg_b = 16'h1234;
    run_cmd("t6_nop7", 1'b1);

    // random commands
    for (int i = 0; i < 40; i++) begin
      int unsigned pat;
      pat = $urandom_range(1, 3);
      bus.op_a  = 3'($urandom_range(0, 7));
      bus.op_b  = 3'($urandom_range(0, 7));
      bus.arg_a = 16'($urandom);
      bus.arg_b = 16'($urandom);
      bus.cnt_a = 4'($urandom_range(0, 15));
      bus.cnt_b = 4'($urandom_range(0, 15));
      bus.req_a = pat[0];
      bus.req_b = pat[1];
      run_cmd($sformatf("rnd%0d", i), $urandom_range(0, 3) != 0);
    end
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("final idle", 32'(obs_vec()), 32'({11'b0, model_owner}));

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
